// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-zero constant, hazard scoreboard entry and
// multiply/divide latency defaults.
package cpu_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 4;
  localparam int         MDU_CNT_W   = 4;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wa;
    logic       ld;
    logic       mdu;
  } hz_entry_t;

endpackage

// File: rtl/mdu_timer.sv
// Multiply/divide occupancy timer: loads LAT-1 when an MDU op enters EX and
// counts down to zero; busy while the count is nonzero.
module mdu_timer
  import cpu_pkg::*;
#(
  parameter int LAT = MDU_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam logic [MDU_CNT_W-1:0] LOAD_VAL = MDU_CNT_W'(LAT - 1);

  logic [MDU_CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Purely a function of the counter, so an async reset drops busy at once.
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/ME/WB shadow scoreboard, load-use detection,
// branch flush and (with HAZARD_MDU_EN defined) multi-cycle MDU hold of EX.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_use,
  input  logic       id_rt_use,
  input  logic       id_we,
  input  logic [4:0] id_wa,
  input  logic       id_is_load,
  input  logic       id_is_mdu,
  input  logic       flush,
  output logic       stall,
  output logic       ex_bubble,
  output logic       ex_hold,
  output logic       me_bubble,
  output logic       mdu_busy
);

  hz_entry_t ex_q, me_q, wb_q;
  hz_entry_t id_entry;
  logic      id_mdu;
  logic      lu;
  logic      ex_load;

`ifdef HAZARD_MDU_EN
  assign id_mdu = id_is_mdu;

  mdu_timer #(
    .LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk  (clk),
    .rst  (rst),
    .load (ex_load && id_is_mdu),
    .busy (mdu_busy)
  );

  // WB is kept for scoreboard completeness; nothing downstream reads it yet.
  logic sb_unused;
  assign sb_unused = ^wb_q;
`else
  assign id_mdu   = 1'b0;
  assign mdu_busy = 1'b0;

  logic sb_unused;
  assign sb_unused = ^{wb_q, id_is_mdu};
`endif

  assign id_entry = '{v: 1'b1, we: id_we, wa: id_wa, ld: id_is_load, mdu: id_mdu};

  // Only a load still in EX is uncovered; from ME onwards forwarding handles it.
  always_comb begin
    lu = 1'b0;
    if (id_valid && ex_q.v && ex_q.we && ex_q.ld && (ex_q.wa != REG_ZERO)) begin
      lu = (id_rs_use && (id_rs_addr == ex_q.wa)) ||
           (id_rt_use && (id_rt_addr == ex_q.wa));
    end
  end

  assign stall     = (lu && !flush) || mdu_busy;
  assign ex_bubble = !mdu_busy && (lu || flush);
  assign ex_hold   = mdu_busy;
  assign me_bubble = mdu_busy;
  assign ex_load   = id_valid && !stall && !flush;

  // NOTE: every scoreboard entry is reset; stale valid bits would otherwise
  // raise phantom load-use stalls straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
      me_q <= '0;
      wb_q <= '0;
    end else begin
      wb_q <= me_q;
      me_q <= mdu_busy ? '0 : ex_q;
      if (mdu_busy) begin
        ex_q <= ex_q;
      end else if (ex_load) begin
        ex_q <= id_entry;
      end else begin
        ex_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps plus random
// traffic against a cycle-level behavioural model of the pipeline front end.
module tb_hazard_ctrl;

  localparam int LAT = 4;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs_addr = '0, id_rt_addr = '0, id_wa = '0;
  logic       id_rs_use = 1'b0, id_rt_use = 1'b0, id_we = 1'b0;
  logic       id_is_load = 1'b0, id_is_mdu = 1'b0, flush = 1'b0;
  logic       stall, ex_bubble, ex_hold, me_bubble, mdu_busy;

  int checks = 0;
  int errors = 0;

  // Model: what instruction sits in EX and how many more cycles it must stay.
  bit       m_ex_v;
  bit       m_ex_ld;
  int       m_ex_dst;   // -1 when the EX instruction writes nothing useful
  int       m_left;
  bit       e_stall, e_bubble, e_busy;

  hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_rs_use  (id_rs_use),
    .id_rt_use  (id_rt_use),
    .id_we      (id_we),
    .id_wa      (id_wa),
    .id_is_load (id_is_load),
    .id_is_mdu  (id_is_mdu),
    .flush      (flush),
    .stall      (stall),
    .ex_bubble  (ex_bubble),
    .ex_hold    (ex_hold),
    .me_bubble  (me_bubble),
    .mdu_busy   (mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex_v   = 1'b0;
    m_ex_ld  = 1'b0;
    m_ex_dst = -1;
    m_left   = 0;
  endtask

  task automatic model_eval();
    bit hit;
    e_busy = MDU_EN && (m_left > 0);
    hit = id_valid && m_ex_v && m_ex_ld && (m_ex_dst > 0) &&
          ((id_rs_use && int'(id_rs_addr) == m_ex_dst) ||
           (id_rt_use && int'(id_rt_addr) == m_ex_dst));
    e_stall  = (hit && !flush) || e_busy;
    e_bubble = !e_busy && (hit || flush);
  endtask

  // Called at a negedge: drive ID, let logic settle, compare all outputs.
  task automatic apply(input string tag, input bit v, input int rs, input int rt,
                       input bit rsu, input bit rtu, input bit we, input int wa,
                       input bit ld, input bit mdu, input bit fl);
    id_valid   = v;
    id_rs_addr = 5'(rs);
    id_rt_addr = 5'(rt);
    id_rs_use  = rsu;
    id_rt_use  = rtu;
    id_we      = we;
    id_wa      = 5'(wa);
    id_is_load = ld;
    id_is_mdu  = mdu;
    flush      = fl;
    #1;
    model_eval();
    chk({tag, ".stall"},     stall,     e_stall);
    chk({tag, ".ex_bubble"}, ex_bubble, e_bubble);
    chk({tag, ".ex_hold"},   ex_hold,   e_busy);
    chk({tag, ".me_bubble"}, me_bubble, e_busy);
    chk({tag, ".mdu_busy"},  mdu_busy,  e_busy);
  endtask

  // Advance one clock and move the model forward with the inputs just applied.
  task automatic tick();
    @(posedge clk);
    model_eval();
    if (e_busy) begin
      m_left--;
    end else if (id_valid && !e_stall && !flush) begin
      m_ex_v   = 1'b1;
      m_ex_ld  = id_is_load;
      m_ex_dst = (id_we && id_wa != 0) ? int'(id_wa) : -1;
      m_left   = (MDU_EN && id_is_mdu) ? LAT - 1 : 0;
    end else begin
      m_ex_v   = 1'b0;
      m_ex_ld  = 1'b0;
      m_ex_dst = -1;
    end
    @(negedge clk);
  endtask

  task automatic nop_cycle(input string tag);
    apply(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    chk("reset.stall",     stall,     1'b0);
    chk("reset.ex_bubble", ex_bubble, 1'b0);
    chk("reset.ex_hold",   ex_hold,   1'b0);
    chk("reset.me_bubble", me_bubble, 1'b0);
    chk("reset.mdu_busy",  mdu_busy,  1'b0);
    @(negedge clk);
    rst = 1'b1;

    // lw $8 then add $9,$8,$3: one bubble, then the add proceeds.
    apply("lw8",   1, 0, 0, 0, 0, 1, 8, 1, 0, 0);  tick();
    apply("lu1",   1, 8, 3, 1, 1, 1, 9, 0, 0, 0);
    chk("lu1.stall_const", stall, 1'b1);
    chk("lu1.bubble_const", ex_bubble, 1'b1);
    tick();
    apply("lu2",   1, 8, 3, 1, 1, 1, 9, 0, 0, 0);
    chk("lu2.stall_const", stall, 1'b0);
    tick();

    // Load to $0, and a matching address that is not actually read.
    apply("lw0",   1, 0, 0, 0, 0, 1, 0, 1, 0, 0);  tick();
    apply("use0",  1, 0, 0, 1, 1, 1, 9, 0, 0, 0);
    chk("use0.stall_const", stall, 1'b0);
    tick();
    apply("lw5",   1, 0, 0, 0, 0, 1, 5, 1, 0, 0);  tick();
    apply("nouse", 1, 5, 5, 0, 0, 1, 9, 0, 0, 0);
    chk("nouse.bubble_const", ex_bubble, 1'b0);
    tick();

    // Load-use and flush together: flush wins, EX then empty.
    apply("lw7",   1, 0, 0, 0, 0, 1, 7, 1, 0, 0);  tick();
    apply("lufl",  1, 1, 7, 0, 1, 1, 9, 0, 0, 1);
    chk("lufl.stall_const", stall, 1'b0);
    chk("lufl.bubble_const", ex_bubble, 1'b1);
    tick();
    apply("after_fl", 1, 7, 7, 1, 1, 1, 2, 0, 0, 0);
    chk("after_fl.stall_const", stall, 1'b0);
    tick();

    // mult enters EX at cycle N; busy for N+1..N+3 only when MDU support is built.
    apply("mult", 1, 1, 2, 1, 1, 1, 3, 0, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("mdu%0d", i), 1, 4, 5, 1, 1, 1, 6, 0, 0, 0);
      chk($sformatf("mdu%0d.busy_const", i), mdu_busy, MDU_EN && (i < 3));
      tick();
    end

    // Reset while the counter holds 2: outputs clear without a clock edge.
    apply("mult2", 1, 1, 2, 1, 1, 1, 3, 0, 1, 0);  tick();
    nop_cycle("mult2_c3");
    id_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rstmid.stall",     stall,     1'b0);
    chk("rstmid.ex_bubble", ex_bubble, 1'b0);
    chk("rstmid.ex_hold",   ex_hold,   1'b0);
    chk("rstmid.me_bubble", me_bubble, 1'b0);
    chk("rstmid.mdu_busy",  mdu_busy,  1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply("post_rst", 1, 3, 4, 1, 1, 1, 5, 0, 0, 0);
    chk("post_rst.stall_const", stall, 1'b0);
    tick();

    // Random traffic over a small register window to provoke frequent hazards.
    for (int c = 0; c < 400; c++) begin
      apply($sformatf("rnd%0d", c),
            $urandom_range(7, 0) != 0,
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            1'($urandom), 1'($urandom), 1'($urandom_range(3, 0) != 0),
            int'($urandom_range(3, 0)),
            $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0,
            $urandom_range(7, 0) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
